hdmi_line_buffer: RTL and testbench
===================================

// Module: hdmi_line_buffer
// PURPOSE
//  Ping-pong scanline buffer feeding the rgb input of hdmi_selection. Captures one VDP line of 24-bit
//  pixels, replays it line-doubled (each source line on 2 output lines) at output position (cx,cy).
//  Centres the picture in the 720-wide active area; drives border_rgb elsewhere. Single clk_pixel domain.
// PARAMETERS
//  LINE_WIDTH   512  max pixels per source line (buffer depth per bank)
//  H_OFFSET     104  cx of first displayed pixel; window = [H_OFFSET, H_OFFSET+LINE_WIDTH)
//  V_OFFSET_NTSC 26  cy of first displayed output line, NTSC (VIC 2)
//  V_OFFSET_PAL  50  cy of first displayed output line, PAL (VIC 17)
//  V_LINES      212  source lines per field (window = 2*V_LINES output lines)
// PORTS
//  clk_pixel       in   1   pixel clock; sole clock
//  reset           in   1   synchronous, active-high
//  pal_mode        in   1   selects V_OFFSET_PAL vs V_OFFSET_NTSC; sampled at cy==0,cx==0 only
//  vdp_line_start  in   1   pulse coincident with first pixel of a source line
//  vdp_pixel_valid in   1   write strobe for vdp_rgb
//  vdp_rgb         in   24  source pixel {R,G,B}
//  border_rgb      in   24  colour outside the window
//  cx              in   11  output x from hdmi_selection
//  cy              in   10  output y from hdmi_selection
//  line_req        out  1   one-cycle pulse: next source line wanted
//  rgb             out  24  pixel to hdmi_selection, registered
//  underrun        out  1   sticky: bank replayed with no new line captured
//  overrun         out  1   sticky: pixel beyond LINE_WIDTH dropped
// BEHAVIOUR
//  Reset: rgb=0, line_req=0, underrun=0, overrun=0, wr_bank=0, rd_bank=1, wr_ptr=0, line_done=0,
//   latched pal_mode=0. Reset mid-line aborts capture; bank contents undefined, no flags set.
//  Write side:
//   - vdp_line_start: wr_bank<=~wr_bank (unless first line after reset), wr_ptr<=0, line_done<=1 if
//     previous line wrote >=1 pixel. Pixel valid in same cycle is written at addr 0 of new bank.
//   - vdp_pixel_valid: write {wr_bank,wr_ptr}, wr_ptr++. wr_ptr==LINE_WIDTH: drop pixel, set overrun.
//  Read side (vo = latched offset):
//   - in_v = cy in [vo, vo+2*V_LINES); in_h = cx in [H_OFFSET, H_OFFSET+LINE_WIDTH).
//   - At cx==0 of an in_v line with (cy-vo) even: if line_done, rd_bank<=~wr_bank, line_done<=0;
//     else keep rd_bank, set underrun (except first in_v line of field). Odd lines reuse rd_bank.
//   - line_req pulses at cx==0 of each even in_v line, and at cy==vo-2,cx==0 to prime field.
//   - Read address = cx-H_OFFSET, 2-cycle latency: RAM registered read + output register. Address
//     and in_h/in_v qualify are pipelined alongside so rgb at cycle t reflects (cx,cy) of t-2;
//     hdmi_selection cx/cy are pre-advanced by 2 accordingly.
//   - rgb = (in_h && in_v) ? ram_q : border_rgb (border also delayed 2).
//  Boundaries: pixels past written length in a bank show stale data (no blanking); cx wrap 0 with
//   line_start same cycle: both actions occur, write side wins bank flip first. Flags clear on reset only.
//  Arithmetic: all comparisons unsigned, 11-bit for x, 10-bit for y; no wrap of windows past frame.
// STRUCTURE
//  Package hdmi_video_pkg: VIC 2/17 active width/height, default offsets, rgb24_t typedef.
//  Sub-module line_buffer_ram: simple dual-port, depth 2*LINE_WIDTH x 24, sync write, registered read.
//  Top: write FSM (IDLE/CAPTURE), read window/bank logic, 2-stage output pipe.
// TESTING
//  1 Reset, feed 2 lines of 512 ramp pixels (rgb=index) -> even/odd output lines at cy=vo,vo+1 show
//    rgb=0..511 across cx=104..615, border elsewhere, 2-cycle latency exact.
//  2 pal_mode=1 at frame start -> first displayed line cy=50; toggle mid-frame -> no change until cy=0.
//  3 Stop VDP after 1 line -> second pair repeats line 1, underrun=1; overrun stays 0.
//  4 Send 520 valid pixels in one line -> pixels 512..519 dropped, overrun=1, RAM addr 0 intact.
//  5 Assert reset mid-capture at pixel 200 -> all outputs reset values next cycle; next full line
//    displays correctly.
//  6 Check line_req: exactly one pulse per even in_v line plus prime at cy=vo-2, none in border.

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// Shared video constants and types for the HDMI output path.
// Holds the VIC 2 (480p NTSC) and VIC 17 (576p PAL) active-area sizes, the default
// placement of the VDP picture inside them, the 24-bit pixel type and the write-side
// state encoding of the line buffer.
package hdmi_video_pkg;

  localparam int unsigned Vic2ActiveWidth   = 720;
  localparam int unsigned Vic2ActiveHeight  = 480;
  localparam int unsigned Vic17ActiveWidth  = 720;
  localparam int unsigned Vic17ActiveHeight = 576;

  localparam int unsigned DefaultLineWidth  = 512;
  localparam int unsigned DefaultVLines     = 212;
  // Centre the source line horizontally: (720 - 512) / 2 = 104.
  localparam int unsigned DefaultHOffset    = (Vic2ActiveWidth - DefaultLineWidth) / 2;
  // Centre 2*212 doubled lines: (480 - 424) / 2 = 28, minus the 2-line prime lead-in.
  localparam int unsigned DefaultVOffsetNtsc = 26;
  // (576 - 424) / 2 = 76 would centre; 50 matches the VDP PAL top border.
  localparam int unsigned DefaultVOffsetPal  = 50;

  typedef logic [23:0] rgb24_t;

  typedef enum logic [0:0] {
    StIdle,
    StCapture
  } wr_state_e;

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port RAM for the line buffer: one synchronous write port and one
// registered read port on the same clock.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  read address
//   rd_data_o  read data, valid the cycle after rd_addr_i
module line_buffer_ram
  import hdmi_video_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  rgb24_t           wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output rgb24_t           rd_data_o
);

  rgb24_t mem [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/hdmi_line_buffer.sv
// Ping-pong scanline buffer between the VDP and hdmi_selection.
// One bank captures the current VDP line while the other is replayed, each source line
// shown on two consecutive output lines, centred in the active area; border_rgb elsewhere.
// Ports:
//   clk_pixel, reset           pixel clock, synchronous active-high reset
//   pal_mode                   offset select, latched at cx==0,cy==0
//   vdp_line_start/pixel_valid VDP line framing and pixel strobe; vdp_rgb pixel data
//   border_rgb                 colour outside the picture window
//   cx, cy                     output position (pre-advanced by 2 for the pipe latency)
//   line_req                   pulse asking the VDP for the next line
//   rgb                        registered output pixel
//   underrun, overrun          sticky error flags
module hdmi_line_buffer
  import hdmi_video_pkg::*;
#(
  parameter int unsigned LINE_WIDTH    = DefaultLineWidth,
  parameter int unsigned H_OFFSET      = DefaultHOffset,
  parameter int unsigned V_OFFSET_NTSC = DefaultVOffsetNtsc,
  parameter int unsigned V_OFFSET_PAL  = DefaultVOffsetPal,
  parameter int unsigned V_LINES       = DefaultVLines
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        pal_mode,
  input  logic        vdp_line_start,
  input  logic        vdp_pixel_valid,
  input  rgb24_t      vdp_rgb,
  input  rgb24_t      border_rgb,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  output logic        line_req,
  output rgb24_t      rgb,
  output logic        underrun,
  output logic        overrun
);

  localparam int unsigned ColW  = $clog2(LINE_WIDTH);
  localparam int unsigned PtrW  = ColW + 1;
  localparam int unsigned AddrW = ColW + 1;

  localparam logic [10:0]     HStart  = 11'(H_OFFSET);
  localparam logic [10:0]     HEnd    = 11'(H_OFFSET + LINE_WIDTH);
  localparam logic [9:0]      VSpan   = 10'(2 * V_LINES);
  localparam logic [PtrW-1:0] PtrFull = PtrW'(LINE_WIDTH);

  wr_state_e       wr_state_q;
  logic            wr_bank_q, rd_bank_q, line_done_q, pal_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic            vis_q;
  rgb24_t          border_q;
  rgb24_t          ram_q;

  logic            wr_bank_d, line_done_w, ram_we, pix_drop;
  logic [PtrW-1:0] wr_ptr_eff, wr_ptr_d;
  logic [9:0]      vo, v_end, v_rel;
  logic            in_v, in_h, row_start, prime_line;
  logic            rd_bank_d, line_done_d, underrun_d, line_req_d;
  logic [ColW-1:0] rd_col;
  logic [AddrW-1:0] wr_addr, rd_addr;

  // Write side: a line start retargets the pixel strobed in the same cycle to address 0
  // of the freshly flipped bank.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_ptr_eff  = wr_ptr_q;
    line_done_w = line_done_q;
    if (vdp_line_start) begin
      wr_ptr_eff = '0;
      // The first line after reset has no predecessor to hand over.
      if (wr_state_q == StCapture) begin
        wr_bank_d = ~wr_bank_q;
        if (wr_ptr_q != '0) begin
          line_done_w = 1'b1;
        end
      end
    end
    ram_we   = vdp_pixel_valid && !reset && (wr_ptr_eff < PtrFull);
    pix_drop = vdp_pixel_valid && (wr_ptr_eff == PtrFull);
    wr_ptr_d = ram_we ? wr_ptr_eff + 1'b1 : wr_ptr_eff;
  end

  // Read side window and bank selection.
  always_comb begin
    vo         = pal_q ? 10'(V_OFFSET_PAL) : 10'(V_OFFSET_NTSC);
    v_end      = vo + VSpan;
    v_rel      = cy - vo;
    in_v       = (cy >= vo) && (cy < v_end);
    in_h       = (cx >= HStart) && (cx < HEnd);
    row_start  = (cx == '0) && in_v && !v_rel[0];
    prime_line = (cy == vo - 10'd2);
    rd_col     = ColW'(cx - HStart);

    rd_bank_d   = rd_bank_q;
    line_done_d = line_done_w;
    underrun_d  = underrun;
    // Even rows pick up a completed line; odd rows repeat the same bank.
    // Uses the post-flip write bank so a same-cycle line start is honoured first.
    if (row_start) begin
      if (line_done_w) begin
        rd_bank_d   = ~wr_bank_d;
        line_done_d = 1'b0;
      end else if (cy != vo) begin
        underrun_d = 1'b1;
      end
    end
    line_req_d = (cx == '0) && (row_start || prime_line);
  end

  assign wr_addr = {wr_bank_d, wr_ptr_eff[ColW-1:0]};
  assign rd_addr = {rd_bank_q, rd_col};

  line_buffer_ram #(
    .Depth (2 * LINE_WIDTH),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i     (clk_pixel),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_addr),
    .wr_data_i (vdp_rgb),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_q)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_state_q  <= StIdle;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      wr_ptr_q    <= '0;
      line_done_q <= 1'b0;
      pal_q       <= 1'b0;
      line_req    <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      vis_q       <= 1'b0;
      border_q    <= '0;
      rgb         <= '0;
    end else begin
      unique case (wr_state_q)
        StIdle:    if (vdp_line_start) wr_state_q <= StCapture;
        StCapture: wr_state_q <= StCapture;
        default:   wr_state_q <= StIdle;
      endcase
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      line_done_q <= line_done_d;
      rd_bank_q   <= rd_bank_d;
      if (cx == '0 && cy == '0) begin
        pal_q <= pal_mode;
      end
      line_req <= line_req_d;
      underrun <= underrun_d;
      if (pix_drop) begin
        overrun <= 1'b1;
      end
      // Stage 1 runs alongside the RAM read; stage 2 is the output register.
      vis_q    <= in_h && in_v;
      border_q <= border_rgb;
      rgb      <= vis_q ? ram_q : border_q;
    end
  end

endmodule

// File: tb/tb_hdmi_line_buffer.sv
module tb_hdmi_line_buffer;
  import hdmi_video_pkg::*;

  logic        clk_pixel = 1'b0;
  logic        reset, pal_mode, vdp_line_start, vdp_pixel_valid;
  rgb24_t      vdp_rgb, border_rgb, rgb;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        line_req, underrun, overrun;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_line_buffer dut (
    .clk_pixel       (clk_pixel),
    .reset           (reset),
    .pal_mode        (pal_mode),
    .vdp_line_start  (vdp_line_start),
    .vdp_pixel_valid (vdp_pixel_valid),
    .vdp_rgb         (vdp_rgb),
    .border_rgb      (border_rgb),
    .cx              (cx),
    .cy              (cy),
    .line_req        (line_req),
    .rgb             (rgb),
    .underrun        (underrun),
    .overrun         (overrun)
  );

  int     checks   = 0;
  int     failures = 0;
  int     exp_vo   = 26;
  int     req_count = 0;
  rgb24_t exp_q[$];
  rgb24_t exp_line [512];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rgb24_t model_pix();
    int ix = int'(cx);
    int iy = int'(cy);
    if (iy >= exp_vo && iy < exp_vo + 424 && ix >= 104 && ix < 616) return exp_line[ix - 104];
    return border_rgb;
  endfunction

  // One clock: push the expected output for the current cx/cy, compare the one due now.
  task automatic step();
    rgb24_t e;
    border_rgb = 24'($urandom());
    exp_q.push_back(model_pix());
    @(posedge clk_pixel);
    #1;
    if (line_req === 1'b1) req_count++;
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      check("rgb", 32'(rgb), 32'(e));
    end
    vdp_line_start  = 1'b0;
    vdp_pixel_valid = 1'b0;
  endtask

  task automatic park();
    cx = 11'd700;
    cy = 10'd500;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vdp_line_start  = 1'b0;
    vdp_pixel_valid = 1'b0;
    @(posedge clk_pixel);
    #1;
    check("reset_rgb", 32'(rgb), 32'h0);
    check("reset_line_req", 32'(line_req), 32'h0);
    check("reset_underrun", 32'(underrun), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic feed_line(input int n, input rgb24_t base);
    int r0 = req_count;
    for (int i = 0; i < n; i++) begin
      vdp_line_start  = (i == 0);
      vdp_pixel_valid = 1'b1;
      vdp_rgb         = base + 24'(i);
      step();
    end
    check("feed_no_line_req", 32'(req_count - r0), 32'h0);
  endtask

  task automatic scan_line(input int y, input int exp_reqs);
    int r0 = req_count;
    cy = 10'(y);
    for (int x = 0; x < 640; x++) begin
      cx = 11'(x);
      step();
    end
    park();
    check($sformatf("line_req_count_cy%0d", y), 32'(req_count - r0), 32'(exp_reqs));
  endtask

  task automatic set_exp(input rgb24_t base);
    for (int i = 0; i < 512; i++) exp_line[i] = base + 24'(i);
  endtask

  task automatic frame_start(input logic pal);
    pal_mode = pal;
    cx = '0;
    cy = '0;
    step();
    park();
    exp_vo = pal ? 50 : 26;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pal_mode = 1'b0;
    vdp_line_start = 1'b0;
    vdp_pixel_valid = 1'b0;
    vdp_rgb = '0;
    border_rgb = '0;
    park();
    reset = 1'b1;
    repeat (2) @(posedge clk_pixel);
    #1;
    do_reset();

    // Two ramp lines (second tagged) give bank 0 = ramp, then prime and display.
    feed_line(512, 24'h000000);
    feed_line(512, 24'h010000);
    check("overrun_after_full_lines", 32'(overrun), 32'h0);
    set_exp(24'h000000);
    scan_line(24, 1);
    scan_line(25, 0);
    scan_line(26, 1);
    scan_line(27, 0);
    check("underrun_first_pair", 32'(underrun), 32'h0);

    // No new line: second pair repeats line 1 and flags underrun.
    scan_line(28, 1);
    scan_line(29, 0);
    check("underrun_starved", 32'(underrun), 32'h1);
    check("overrun_starved", 32'(overrun), 32'h0);

    // PAL latched at frame start; toggling mid-frame has no effect.
    frame_start(1'b1);
    feed_line(512, 24'h020000);
    pal_mode = 1'b0;
    scan_line(26, 0);
    scan_line(48, 1);
    set_exp(24'h010000);
    scan_line(50, 1);
    scan_line(51, 0);
    check("underrun_sticky", 32'(underrun), 32'h1);
    frame_start(1'b0);

    // 520 pixels: the tail is dropped and address 0..7 keep the first pixels.
    feed_line(520, 24'h300000);
    check("overrun_set", 32'(overrun), 32'h1);
    feed_line(4, 24'h400000);
    set_exp(24'h300000);
    scan_line(24, 1);
    scan_line(26, 1);

    // Reset in the middle of a capture, then a clean line.
    feed_line(200, 24'h600000);
    do_reset();
    feed_line(512, 24'h000000);
    feed_line(1, 24'h500000);
    set_exp(24'h000000);
    scan_line(24, 1);
    scan_line(26, 1);
    scan_line(27, 0);
    check("underrun_after_reset", 32'(underrun), 32'h0);
    check("overrun_after_reset", 32'(overrun), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
